// File: rtl/ft245_sync_ctrl.sv
// FT2232H synchronous-FIFO (245 mode) bus controller: arbitrates capped RX/TX bursts
// between the FT bus and the local FIFOs, with a turnaround gap between bursts.
module ft245_sync_ctrl #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_go,
  input  logic              tx_go,
  input  logic              ft_rxf_n,
  input  logic              ft_txe_n,
  input  logic [DATA_W-1:0] ft_data_in,
  output logic [DATA_W-1:0] ft_data_out,
  output logic              ft_data_oe,
  output logic              ft_oe_n,
  output logic              ft_rd_n,
  output logic              ft_wr_n,
  output logic              fa_wr_en,
  output logic [DATA_W-1:0] fa_wr_data,
  input  logic              fa_full,
  output logic              fb_rd_en,
  input  logic [DATA_W-1:0] fb_rd_data,
  input  logic              fb_empty,
  output logic              busy
);

  // state    | meaning
  // IDLE     | bus parked, waiting for a go decision
  // RX_TURN  | FT drives the bus (OE# low), no read strobe yet
  // RX_BURST | FT -> FIFO A, one word per clock
  // TX_BURST | FIFO B -> FT, one word per clock
  // GAP      | one-cycle bus turnaround, everything released

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  typedef enum logic [2:0] {IDLE, RX_TURN, RX_BURST, TX_BURST, GAP} state_t;
  typedef enum logic {DIR_RX, DIR_TX} dir_t;

  state_t            state, state_nxt;
  dir_t              last_dir, last_dir_nxt;
  logic [CNT_W-1:0]  burst_cnt, burst_cnt_nxt;
  logic              oe_n_dec, rd_n_dec, wr_n_dec, data_oe_dec, fa_wr_dec, fb_rd_dec;
  logic              cap_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_dir  <= DIR_TX;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      last_dir  <= last_dir_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    last_dir_nxt  = last_dir;
    burst_cnt_nxt = burst_cnt;
    oe_n_dec      = 1'b1;
    rd_n_dec      = 1'b1;
    wr_n_dec      = 1'b1;
    data_oe_dec   = 1'b0;
    fa_wr_dec     = 1'b0;
    fb_rd_dec     = 1'b0;
    cap_hit       = (burst_cnt == LAST_CNT);
    case (state)
      IDLE: begin
        // with both requests pending, serve the direction that waited last time
        if (rx_go && (!tx_go || last_dir == DIR_TX)) begin
          state_nxt     = RX_TURN;
          burst_cnt_nxt = '0;
        end else if (tx_go) begin
          state_nxt     = TX_BURST;
          burst_cnt_nxt = '0;
        end
      end
      RX_TURN: begin
        oe_n_dec  = 1'b0;
        state_nxt = RX_BURST;
      end
      RX_BURST: begin
        oe_n_dec  = 1'b0;
        rd_n_dec  = fa_full;
        fa_wr_dec = !fa_full && !ft_rxf_n;
        if (fa_wr_dec) burst_cnt_nxt = burst_cnt + CNT_W'(1);
        if (ft_rxf_n || fa_full || (fa_wr_dec && cap_hit)) begin
          state_nxt    = GAP;
          last_dir_nxt = DIR_RX;
        end
      end
      TX_BURST: begin
        data_oe_dec = 1'b1;
        wr_n_dec    = fb_empty;
        fb_rd_dec   = !fb_empty && !ft_txe_n;
        if (fb_rd_dec) burst_cnt_nxt = burst_cnt + CNT_W'(1);
        if (ft_txe_n || fb_empty || (fb_rd_dec && cap_hit)) begin
          state_nxt    = GAP;
          last_dir_nxt = DIR_TX;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // strobes are also gated by rst so nothing fires while reset is held
  assign ft_oe_n     = oe_n_dec | rst;
  assign ft_rd_n     = rd_n_dec | rst;
  assign ft_wr_n     = wr_n_dec | rst;
  assign ft_data_oe  = data_oe_dec & ~rst;
  assign fa_wr_en    = fa_wr_dec & ~rst;
  assign fb_rd_en    = fb_rd_dec & ~rst;
  assign fa_wr_data  = ft_data_in;
  assign ft_data_out = fb_rd_data;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_ft245_sync_ctrl.sv
// Bench for ft245_sync_ctrl: behavioural bus model compared every cycle, FT/FIFO models,
// plus a second instance with MAX_BURST=4 checked against the fixed alternation pattern.
module tb_ft245_sync_ctrl;
  localparam int MAXB     = 64;
  localparam int CAP_MAX  = 4;
  localparam int CAP_PER  = 13;
  localparam int CAP_CYC  = 39;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_go = 1'b0, tx_go = 1'b0;
  logic       ft_rxf_n = 1'b1, ft_txe_n = 1'b1, fa_full = 1'b0, fb_empty = 1'b1;
  logic [7:0] ft_data_in = 8'h00, fb_rd_data = 8'h00;
  logic [7:0] ft_data_out, fa_wr_data;
  logic       ft_data_oe, ft_oe_n, ft_rd_n, ft_wr_n, fa_wr_en, fb_rd_en, busy;

  logic [7:0] c_data_out, c_fa_wr_data;
  logic       c_data_oe, c_oe_n, c_rd_n, c_wr_n, c_fa_wr_en, c_fb_rd_en, c_busy;

  ft245_sync_ctrl #(.DATA_W(8), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .rx_go(rx_go), .tx_go(tx_go),
    .ft_rxf_n(ft_rxf_n), .ft_txe_n(ft_txe_n), .ft_data_in(ft_data_in),
    .ft_data_out(ft_data_out), .ft_data_oe(ft_data_oe), .ft_oe_n(ft_oe_n),
    .ft_rd_n(ft_rd_n), .ft_wr_n(ft_wr_n), .fa_wr_en(fa_wr_en), .fa_wr_data(fa_wr_data),
    .fa_full(fa_full), .fb_rd_en(fb_rd_en), .fb_rd_data(fb_rd_data),
    .fb_empty(fb_empty), .busy(busy)
  );

  ft245_sync_ctrl #(.DATA_W(8), .MAX_BURST(CAP_MAX)) dut_cap (
    .clk(clk), .rst(rst), .rx_go(1'b1), .tx_go(1'b1),
    .ft_rxf_n(1'b0), .ft_txe_n(1'b0), .ft_data_in(8'h00),
    .ft_data_out(c_data_out), .ft_data_oe(c_data_oe), .ft_oe_n(c_oe_n),
    .ft_rd_n(c_rd_n), .ft_wr_n(c_wr_n), .fa_wr_en(c_fa_wr_en), .fa_wr_data(c_fa_wr_data),
    .fa_full(1'b0), .fb_rd_en(c_fb_rd_en), .fb_rd_data(8'h00),
    .fb_empty(1'b0), .busy(c_busy)
  );

  always #5 clk = ~clk;

  // model: m_dir 0 = none, 1 = rx, 2 = tx; m_age = cycles spent in the current burst
  int  m_dir = 0, m_age = 0, m_words = 0, m_last = 2;
  bit  m_gap = 1'b0;
  bq_t rx_src, fb_q, rx_log, tx_log;
  bit  pop_rx = 1'b0, pop_fb = 1'b0;
  int  busy_cnt = 0, wr_lo = 0, cap_k = 0;
  int  n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic refresh();
    ft_rxf_n   = (rx_src.size() == 0);
    ft_data_in = (rx_src.size() != 0) ? rx_src[0] : 8'h00;
    fb_empty   = (fb_q.size() == 0);
    fb_rd_data = (fb_q.size() != 0) ? fb_q[0] : 8'h00;
  endtask

  task automatic do_cycle();
    logic [22:0] act, exp;
    logic [6:0]  c_act, c_exp;
    logic e_oe_n, e_rd_n, e_wr_n, e_doe, e_wa, e_rb, e_busy, rx_data, tx_on, blocked;
    int p;
    act = {ft_oe_n, ft_rd_n, ft_wr_n, ft_data_oe, fa_wr_en, fb_rd_en, busy, fa_wr_data, ft_data_out};
    if (rst) begin
      exp = {7'b1110000, ft_data_in, fb_rd_data};
      m_dir = 0; m_age = 0; m_words = 0; m_gap = 1'b0; m_last = 2;
    end else begin
      rx_data = (m_dir == 1) && (m_age != 0);
      tx_on   = (m_dir == 2);
      e_oe_n  = !(m_dir == 1);
      e_rd_n  = !(rx_data && !fa_full);
      e_wa    = rx_data && !fa_full && !ft_rxf_n;
      e_wr_n  = !(tx_on && !fb_empty);
      e_rb    = tx_on && !fb_empty && !ft_txe_n;
      e_doe   = tx_on;
      e_busy  = m_gap || (m_dir != 0);
      exp = {e_oe_n, e_rd_n, e_wr_n, e_doe, e_wa, e_rb, e_busy, ft_data_in, fb_rd_data};
      if (m_gap) m_gap = 1'b0;
      else if (m_dir == 0) begin
        if (rx_go && (!tx_go || m_last == 2)) begin m_dir = 1; m_age = 0; m_words = 0; end
        else if (tx_go) begin m_dir = 2; m_age = 0; m_words = 0; end
      end else if (m_dir == 1 && m_age == 0) m_age = 1;
      else begin
        if (e_wa || e_rb) m_words++;
        blocked = (m_dir == 1) ? (ft_rxf_n || fa_full) : (ft_txe_n || fb_empty);
        if (blocked || m_words == MAXB) begin m_last = m_dir; m_dir = 0; m_gap = 1'b1; end
        m_age++;
      end
    end
    check($sformatf("bus@%0t", $time), 32'(act), 32'(exp));
    if (fa_wr_en && !rst) rx_log.push_back(fa_wr_data);
    if (fb_rd_en && !rst) tx_log.push_back(ft_data_out);
    pop_rx = fa_wr_en && !rst;
    pop_fb = fb_rd_en && !rst;
    if (busy) busy_cnt++;
    if (!ft_wr_n) wr_lo++;
    // cap instance: RX turn + 4 reads + gap + idle, then 4 writes + gap + idle
    if (!rst && cap_k < CAP_CYC) begin
      p = cap_k % CAP_PER;
      c_exp = {!(p >= 1 && p <= 5), !(p >= 2 && p <= 5), !(p >= 8 && p <= 11),
               (p >= 8 && p <= 11), (p >= 2 && p <= 5), (p >= 8 && p <= 11),
               !(p == 0 || p == 7)};
      c_act = {c_oe_n, c_rd_n, c_wr_n, c_data_oe, c_fa_wr_en, c_fb_rd_en, c_busy};
      check($sformatf("cap[%0d]", cap_k), 32'({c_act, c_fa_wr_data, c_data_out}), 32'({c_exp, 16'h0000}));
      cap_k++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    do_cycle();
    @(posedge clk);
    if (pop_rx && rx_src.size() != 0) rx_src.delete(0);
    if (pop_fb && fb_q.size() != 0) fb_q.delete(0);
    #1;
    refresh();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 100) begin step(); n++; end
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_log(input string name, input bq_t got, input bq_t exp);
    check({name, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s[%0d]", name, i), (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
  endtask

  initial begin
    bq_t e;
    int b0, w0, n;
    refresh();
    repeat (3) step();
    check("reset_strobes", 32'({ft_oe_n, ft_rd_n, ft_wr_n, ft_data_oe, fa_wr_en, fb_rd_en, busy}), 32'(7'b1110000));
    rst = 1'b0;

    // basic RX: 5 words then RXF# high
    rx_src = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15}; refresh();
    rx_go = 1'b1; b0 = busy_cnt;
    step(); rx_go = 1'b0;
    wait_idle("rx_basic");
    check("rx_basic_busy", 32'(busy_cnt - b0), 32'd8);
    e = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15}; check_log("rx_basic_log", rx_log, e); rx_log.delete();

    // basic TX: 4 words, exit on FIFO B empty
    fb_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3}; refresh();
    ft_txe_n = 1'b0; tx_go = 1'b1; w0 = wr_lo;
    step(); tx_go = 1'b0;
    wait_idle("tx_basic");
    check("tx_basic_wr_lo", 32'(wr_lo - w0), 32'd4);
    e = '{8'hA0, 8'hA1, 8'hA2, 8'hA3}; check_log("tx_basic_log", tx_log, e); tx_log.delete();

    // TX with TXE# high for one cycle mid-burst
    fb_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5}; refresh();
    tx_go = 1'b1;
    step(); step(); step();
    ft_txe_n = 1'b1; step(); ft_txe_n = 1'b0;
    n = 0;
    while (fb_q.size() != 0 && n < 40) begin step(); n++; end
    check("tx_toggle_drain", 32'(fb_q.size()), 32'd0);
    tx_go = 1'b0;
    wait_idle("tx_toggle");
    e = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5}; check_log("tx_toggle_log", tx_log, e); tx_log.delete();

    // RX backpressure: FIFO A fills after word 3
    rx_src = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25}; refresh();
    rx_go = 1'b1;
    step(); rx_go = 1'b0;
    repeat (4) step();
    fa_full = 1'b1; #1;
    check("bp_rd_release", 32'({ft_rd_n, fa_wr_en}), 32'(2'b10));
    wait_idle("rx_bp");
    fa_full = 1'b0;
    e = '{8'h21, 8'h22, 8'h23}; check_log("rx_bp_log", rx_log, e); rx_log.delete();
    rx_src.delete(); refresh();

    // stale rx_go: RXF# already high
    rx_go = 1'b1; b0 = busy_cnt;
    step(); rx_go = 1'b0;
    wait_idle("stale");
    check("stale_busy", 32'(busy_cnt - b0), 32'd3);
    check("stale_writes", 32'(rx_log.size()), 32'd0);

    while (cap_k < CAP_CYC) step();

    // reset during the second RX word; last burst was RX, so only reset makes RX win
    rx_src = '{8'h31, 8'h32, 8'h33, 8'h34}; refresh();
    rx_go = 1'b1;
    step(); step(); step();
    tx_go = 1'b1; fb_q = '{8'hC0, 8'hC1}; refresh();
    rst = 1'b1; #1;
    check("rst_async", 32'({ft_oe_n, ft_rd_n, ft_wr_n, ft_data_oe, fa_wr_en, fb_rd_en, busy}), 32'(7'b1110000));
    step(); rst = 1'b0;
    step();
    check("rst_rx_pref", 32'({ft_oe_n, ft_data_oe, busy}), 32'(3'b001));
    rx_go = 1'b0;
    n = 0;
    while (rx_src.size() != 0 && n < 40) begin step(); n++; end
    check("rst_rx_drain", 32'(rx_src.size()), 32'd0);
    n = 0;
    while (fb_q.size() != 0 && n < 40) begin step(); n++; end
    check("rst_tx_drain", 32'(fb_q.size()), 32'd0);
    tx_go = 1'b0;
    wait_idle("rst_seq");
    e = '{8'h31, 8'h32, 8'h33, 8'h34}; check_log("rst_rx_log", rx_log, e); rx_log.delete();
    e = '{8'hC0, 8'hC1}; check_log("rst_tx_log", tx_log, e); tx_log.delete();
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1);
  end

endmodule
